// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style display responder: instruction
// codes, bus sample layout, FSM encoding and the instruction classifier.
package lcd_pkg;

  localparam logic [7:0] CMD_CLEAR   = 8'h01;
  localparam logic [7:0] CMD_HOME    = 8'h02;
  localparam logic [7:0] CMD_ENTRY   = 8'h04;
  localparam logic [7:0] CMD_DISPLAY = 8'h08;
  localparam logic [7:0] CMD_SHIFT   = 8'h10;
  localparam logic [7:0] CMD_FUNC    = 8'h20;
  localparam logic [7:0] CMD_CGRAM   = 8'h40;
  localparam logic [7:0] CMD_DDRAM   = 8'h80;

  localparam logic [7:0] CHAR_SPACE = 8'h20;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_CLEARING = 2'd1;
  localparam logic [1:0] ST_BUSY     = 2'd2;

  typedef enum logic [3:0] {
    K_NOP, K_CLEAR, K_HOME, K_ENTRY, K_DISPLAY,
    K_SHIFT, K_FUNC, K_CGRAM, K_DDRAM
  } cmd_kind_e;

  typedef struct packed {
    logic       rs;
    logic       rw;
    logic       en;
    logic [7:0] data;
  } bus_t;

  // The instruction is identified by its most significant set bit.
  function automatic cmd_kind_e decode_cmd(input logic [7:0] c);
    cmd_kind_e k;
    if      (|(c & CMD_DDRAM))   k = K_DDRAM;
    else if (|(c & CMD_CGRAM))   k = K_CGRAM;
    else if (|(c & CMD_FUNC))    k = K_FUNC;
    else if (|(c & CMD_SHIFT))   k = K_SHIFT;
    else if (|(c & CMD_DISPLAY)) k = K_DISPLAY;
    else if (|(c & CMD_ENTRY))   k = K_ENTRY;
    else if (|(c & CMD_HOME))    k = K_HOME;
    else if (|(c & CMD_CLEAR))   k = K_CLEAR;
    else                         k = K_NOP;
    return k;
  endfunction

endpackage

// File: rtl/lcd_bus_sync.sv
// Brings the asynchronous LCD bus into the clk domain and flags the
// falling edge of en, with operands taken from the oldest stage.
module lcd_bus_sync
  import lcd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       rs,
  input  logic       rw,
  input  logic       en,
  input  logic [7:0] data_in,
  output bus_t       bus_q,
  output logic       strobe
);

  bus_t s1_reg, s2_reg, s3_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_reg <= '0;
      s2_reg <= '0;
      s3_reg <= '0;
    end else begin
      s1_reg <= {rs, rw, en, data_in};
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  assign bus_q  = s3_reg;
  assign strobe = !s2_reg.en && s3_reg.en;

endmodule

// File: rtl/lcd_hd44780_responder.sv
// Display-side model of an 8-bit HD44780 bus: instruction decode, DDRAM
// buffer with scan port, cursor/entry state, busy timing and bus read-back.
module lcd_hd44780_responder
  import lcd_pkg::*;
#(
  parameter  int DDRAM_DEPTH  = 32,
  parameter  int BUSY_CYCLES  = 40,
  parameter  int CLEAR_CYCLES = 1600,
  localparam int AW           = $clog2(DDRAM_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rs,
  input  logic          rw,
  input  logic          en,
  input  logic [7:0]    data_in,
  output logic [7:0]    data_out,
  output logic          data_oe,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_char,
  output logic [AW-1:0] cursor_addr,
  output logic          display_on,
  output logic          cursor_on,
  output logic          busy,
  output logic          protocol_err
);

  localparam int CMAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] LOAD_BUSY  = CW'(BUSY_CYCLES - 1);
  localparam logic [CW-1:0] LOAD_HOME  = CW'(CLEAR_CYCLES - 1);
  localparam logic [CW-1:0] LOAD_CLEAR = CW'(CLEAR_CYCLES - DDRAM_DEPTH);
  localparam logic [AW-1:0] IDX_LAST   = AW'(DDRAM_DEPTH - 1);

  bus_t      bus;
  logic      strobe;
  cmd_kind_e kind;

  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] count_reg, count_next;
  logic [AW-1:0] idx_reg, idx_next;
  logic [AW-1:0] cursor_reg, cursor_next;
  logic          incr_reg, incr_next;
  logic          disp_reg, disp_next;
  logic          curs_on_reg, curs_on_next;
  logic          err_reg, err_next;
  logic          busy_reg;
  logic [7:0]    data_out_reg;
  logic          data_oe_reg;
  logic [7:0]    rd_char_reg;

  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic [7:0]    mem [DDRAM_DEPTH];

  lcd_bus_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .rs      (rs),
    .rw      (rw),
    .en      (en),
    .data_in (data_in),
    .bus_q   (bus),
    .strobe  (strobe)
  );

  assign kind = decode_cmd(bus.data);

  function automatic logic [AW-1:0] step(input logic [AW-1:0] a, input logic up);
    return up ? a + AW'(1) : a - AW'(1);
  endfunction

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    idx_next     = idx_reg;
    cursor_next  = cursor_reg;
    incr_next    = incr_reg;
    disp_next    = disp_reg;
    curs_on_next = curs_on_reg;
    err_next     = 1'b0;
    we           = 1'b0;
    waddr        = cursor_reg;
    wdata        = bus.data;

    case (state_reg)
      ST_CLEARING: begin
        we    = 1'b1;
        waddr = idx_reg;
        wdata = CHAR_SPACE;
        if (idx_reg == IDX_LAST) begin
          state_next = ST_BUSY;
          count_next = LOAD_CLEAR;
        end else begin
          idx_next = idx_reg + AW'(1);
        end
      end
      ST_BUSY: begin
        if (count_reg == '0) state_next = ST_IDLE;
        else                 count_next = count_reg - CW'(1);
      end
      default: ;
    endcase

    // Status reads never touch state; everything else needs an idle controller.
    if (strobe && !(bus.rw && !bus.rs)) begin
      if (state_reg != ST_IDLE) begin
        err_next = 1'b1;
      end else begin
        state_next = ST_BUSY;
        count_next = LOAD_BUSY;
        if (bus.rw) begin
          cursor_next = step(cursor_reg, incr_reg);
        end else if (bus.rs) begin
          we          = 1'b1;
          waddr       = cursor_reg;
          wdata       = bus.data;
          cursor_next = step(cursor_reg, incr_reg);
        end else begin
          case (kind)
            K_CLEAR: begin
              state_next  = ST_CLEARING;
              idx_next    = '0;
              cursor_next = '0;
              incr_next   = 1'b1;
            end
            K_HOME: begin
              cursor_next = '0;
              count_next  = LOAD_HOME;
            end
            K_ENTRY:   incr_next = bus.data[1];
            K_DISPLAY: begin
              disp_next    = bus.data[2];
              curs_on_next = bus.data[1];
            end
            K_SHIFT: begin
              if (!bus.data[3]) cursor_next = step(cursor_reg, bus.data[2]);
            end
            K_DDRAM:   cursor_next = bus.data[AW-1:0];
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_CLEARING;
      count_reg    <= '0;
      idx_reg      <= '0;
      cursor_reg   <= '0;
      incr_reg     <= 1'b1;
      disp_reg     <= 1'b0;
      curs_on_reg  <= 1'b0;
      err_reg      <= 1'b0;
      busy_reg     <= 1'b1;
      data_out_reg <= '0;
      data_oe_reg  <= 1'b0;
      rd_char_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      count_reg    <= count_next;
      idx_reg      <= idx_next;
      cursor_reg   <= cursor_next;
      incr_reg     <= incr_next;
      disp_reg     <= disp_next;
      curs_on_reg  <= curs_on_next;
      err_reg      <= err_next;
      busy_reg     <= (state_next != ST_IDLE);
      data_out_reg <= bus.rs ? mem[cursor_reg] : {busy_reg, 7'(cursor_reg)};
      data_oe_reg  <= bus.en && bus.rw;
      rd_char_reg  <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign data_out     = data_out_reg;
  assign data_oe      = data_oe_reg;
  assign rd_char      = rd_char_reg;
  assign cursor_addr  = cursor_reg;
  assign display_on   = disp_reg;
  assign cursor_on    = curs_on_reg;
  assign busy         = busy_reg;
  assign protocol_err = err_reg;

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed bench for the LCD responder: reset/clear timing, instruction and
// data writes, wrap, entry mode, busy drops, status/data reads, mid-clear reset.
module tb_lcd_hd44780_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic       rs, rw, en;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       data_oe;
  logic [4:0] rd_addr;
  logic [7:0] rd_char;
  logic [4:0] cursor_addr;
  logic       display_on, cursor_on, busy, protocol_err;

  int errors = 0;
  int checks = 0;
  int err_pulses = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (protocol_err === 1'b1) err_pulses++;

  lcd_hd44780_responder #(
    .DDRAM_DEPTH  (32),
    .BUSY_CYCLES  (40),
    .CLEAR_CYCLES (1600)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rs           (rs),
    .rw           (rw),
    .en           (en),
    .data_in      (data_in),
    .data_out     (data_out),
    .data_oe      (data_oe),
    .rd_addr      (rd_addr),
    .rd_char      (rd_char),
    .cursor_addr  (cursor_addr),
    .display_on   (display_on),
    .cursor_on    (cursor_on),
    .busy         (busy),
    .protocol_err (protocol_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_access(input logic r_s, input logic r_w, input logic [7:0] d);
    @(negedge clk);
    rs = r_s; rw = r_w; data_in = d; en = 1'b1;
    repeat (4) @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy, 0);
  endtask

  task automatic wr(input logic r_s, input logic [7:0] d, input string tag);
    bus_access(r_s, 1'b0, d);
    wait_idle(tag);
  endtask

  task automatic scan(input logic [4:0] a, input logic [7:0] exp, input string tag);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    check(tag, rd_char, exp);
  endtask

  task automatic release_and_count(input string tag);
    int n = 0;
    @(negedge clk);
    reset = 1'b1;
    while (busy === 1'b1 && n < 5000) begin
      n++;
      @(negedge clk);
    end
    check(tag, n, 1601);
  endtask

  task automatic read_hold(input logic r_s, input logic [7:0] exp, input string tag);
    @(negedge clk);
    rs = r_s; rw = 1'b1; en = 1'b1;
    repeat (5) @(negedge clk);
    check({tag, "_oe"}, data_oe, 1);
    check({tag, "_data"}, data_out, exp);
    en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; rs = 1'b0; rw = 1'b0; en = 1'b0; data_in = 8'h00; rd_addr = 5'd0;
    #2 reset = 1'b0;

    // Reset values
    @(negedge clk);
    check("rst_busy", busy, 1);
    check("rst_oe", data_oe, 0);
    check("rst_dout", data_out, 8'h00);
    check("rst_rdchar", rd_char, 8'h00);
    check("rst_cursor", cursor_addr, 0);
    check("rst_disp", display_on, 0);
    check("rst_curon", cursor_on, 0);
    check("rst_err", protocol_err, 0);

    // Power-on clear
    release_and_count("clear_busy_len");
    for (int a = 0; a < 32; a++) scan(5'(a), 8'h20, $sformatf("scan%0d", a));
    check("cursor_after_clear", cursor_addr, 0);

    // Init sequence
    wr(1'b0, 8'h38, "idle_38");
    wr(1'b0, 8'h0C, "idle_0c");
    wr(1'b0, 8'h01, "idle_01");
    wr(1'b0, 8'h06, "idle_06");
    check("init_disp", display_on, 1);
    check("init_curon", cursor_on, 0);
    check("init_cursor", cursor_addr, 0);
    check("init_noerr", err_pulses, 0);

    // "WASH"
    wr(1'b1, 8'h57, "idle_W");
    wr(1'b1, 8'h41, "idle_A");
    wr(1'b1, 8'h53, "idle_S");
    wr(1'b1, 8'h48, "idle_H");
    scan(5'd0, 8'h57, "wash0");
    scan(5'd1, 8'h41, "wash1");
    scan(5'd2, 8'h53, "wash2");
    scan(5'd3, 8'h48, "wash3");
    check("wash_cursor", cursor_addr, 4);

    // Wrap on increment
    wr(1'b0, 8'h9F, "idle_9f");
    check("ddram_set31", cursor_addr, 31);
    wr(1'b1, 8'h58, "idle_X");
    wr(1'b1, 8'h59, "idle_Y");
    scan(5'd31, 8'h58, "wrap_x31");
    scan(5'd0, 8'h59, "wrap_y0");
    check("wrap_cursor", cursor_addr, 1);

    // Decrement entry mode and wrap downwards
    wr(1'b0, 8'h04, "idle_04");
    wr(1'b0, 8'h80, "idle_80");
    wr(1'b1, 8'h5A, "idle_Z");
    scan(5'd0, 8'h5A, "dec_z0");
    check("dec_cursor", cursor_addr, 31);

    // Cursor shift left/right, display-shift ignored
    wr(1'b0, 8'h10, "idle_10");
    check("shift_left", cursor_addr, 30);
    wr(1'b0, 8'h14, "idle_14");
    check("shift_right", cursor_addr, 31);
    wr(1'b0, 8'h18, "idle_18");
    check("disp_shift_noop", cursor_addr, 31);

    // Data read at cursor 0 with increment restored
    wr(1'b0, 8'h06, "idle_06b");
    wr(1'b0, 8'h80, "idle_80b");
    read_hold(1'b1, 8'h5A, "dread");
    wait_idle("idle_dread");
    check("dread_cursor", cursor_addr, 1);

    // Busy, status read and dropped write
    wr(1'b0, 8'h85, "idle_85");
    bus_access(1'b1, 1'b0, 8'h41);
    read_hold(1'b0, 8'h86, "status_busy");
    bus_access(1'b1, 1'b0, 8'h42);
    check("drop_err_pulse", err_pulses, 1);
    wait_idle("idle_after_drop");
    scan(5'd5, 8'h41, "busy_a5");
    scan(5'd6, 8'h20, "drop_keep6");
    check("drop_cursor", cursor_addr, 6);
    read_hold(1'b0, 8'h06, "status_idle");
    check("status_noerr", err_pulses, 1);

    // Reset in the middle of a clear
    bus_access(1'b0, 1'b0, 8'h01);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_busy", busy, 1);
    check("midrst_disp", display_on, 0);
    check("midrst_cursor", cursor_addr, 0);
    check("midrst_oe", data_oe, 0);
    check("midrst_dout", data_out, 8'h00);
    check("midrst_err", protocol_err, 0);
    release_and_count("midrst_clear_len");
    scan(5'd31, 8'h20, "midrst_scan31");
    scan(5'd5, 8'h20, "midrst_scan5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lcd_hd44780_responder.md
Name: lcd_hd44780_responder

Overview:
- Synthesizable model of the display side of the HD44780-style parallel bus that our LCD writer drives (rs/rw/en/data, 8-bit mode).
- Samples bus strobes, decodes instructions, and maintains a DDRAM character buffer, cursor, entry mode, display flags and the busy flag.
- Serves busy-flag/address and DDRAM reads back onto the bus.
- Used as an on-chip LCD stand-in for FPGA bring-up, and as the responder in writer testbenches.

Parameters:
- DDRAM_DEPTH, 32: characters in the buffer. Power of two; address width AW = clog2(DDRAM_DEPTH).
- BUSY_CYCLES, 40: clk cycles busy after a normal accepted access. Must be ≥ 1.
- CLEAR_CYCLES, 1600: clk cycles busy after clear/home/reset. Must be ≥ DDRAM_DEPTH.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset; asserted when 0.
- rs  in  1  register select: 0 = instruction, 1 = data.
- rw  in  1  1 = read, 0 = write.
- en  in  1  bus enable, asynchronous to clk; access completes on its falling edge.
- data_in  in  8  bus write data.
- data_out  out  8  bus read data.
- data_oe  out  1  drive-enable for data_out.
- rd_addr  in  AW  scan-port address.
- rd_char  out  8  DDRAM[rd_addr], 1-cycle registered latency.
- cursor_addr  out  AW  current address counter.
- display_on  out  1  display-control bit D.
- cursor_on  out  1  display-control bit C.
- busy  out  1  busy flag.
- protocol_err  out  1  1-cycle pulse when an access is dropped.

Behaviour:
- Reset values: data_out=0, data_oe=0, rd_char=0, cursor_addr=0, display_on=0, cursor_on=0, busy=1, protocol_err=0, entry increment=1, FSM=CLEARING, clear index=0.
- Input sync: rs, rw, en and data_in pass together through a 2-flop synchronizer, then a third register stage.
- Strobe: fires on the cycle where en stage-2=0 and stage-3=1. Operands come from the stage-3 copies. Strobe occurs 3 clk after en falls at the pin; effects are visible the following cycle.
- FSM states:
  - CLEARING: write 0x20 to DDRAM[idx], one entry per cycle, idx 0..DDRAM_DEPTH-1. Then go to BUSY with remaining count CLEAR_CYCLES-DDRAM_DEPTH.
  - BUSY: count down; enter IDLE when the count reaches 0.
  - IDLE: accepts accesses.
- busy is registered and equals (state != IDLE).
- Write-busy timing: a write accepted at cycle T gives busy=1 over T+1..T+BUSY_CYCLES, and IDLE at T+BUSY_CYCLES+1.
- Instruction write (rs=0, rw=0), decoded by the highest set bit of data:
  - 0x80-0xFF: cursor = data[AW-1:0].
  - 0x40-0x7F: CGRAM address; ignored.
  - 0x20-0x3F: function set; no state change.
  - 0x10-0x1F: if bit3=0, cursor ±1 per bit2 (1 = right) with wrap mod DDRAM_DEPTH. If bit3=1 (display shift), no effect.
  - 0x08-0x0F: display_on=bit2, cursor_on=bit1; blink bit ignored.
  - 0x04-0x07: increment = bit1; bit0 ignored.
  - 0x02-0x03: cursor=0; busy CLEAR_CYCLES.
  - 0x01: go to CLEARING; cursor=0; increment=1.
  - 0x00: no-op; busy BUSY_CYCLES.
  - Every instruction except clear/home sets busy for BUSY_CYCLES.
- Data write (rs=1, rw=0): DDRAM[cursor] = data, then cursor ±1 per increment, wrapping mod DDRAM_DEPTH (31→0 on increment, 0→31 on decrement).
- Status read (rs=0, rw=1):
  - data_oe=1 while synchronized en=1 and rw=1.
  - data_out = {busy, 7-bit zero-extended cursor}.
  - Allowed while busy; no state change; does not start busy.
- Data read (rs=1, rw=1):
  - data_out = DDRAM[cursor] while en high.
  - On strobe, cursor advances per increment and busy is set for BUSY_CYCLES.
- Any write or data read strobed while busy=1: dropped, protocol_err=1 for one cycle, busy count unchanged.
- Scan port reads are independent of FSM state. During CLEARING they may return old or 0x20 data.
- Reset asserted in any state returns all reset values; clearing restarts on release.

Decomposition:
- Shared package lcd_pkg:
  - instruction masks/codes (CMD_CLEAR, CMD_HOME, CMD_ENTRY, CMD_DISPLAY, CMD_SHIFT, CMD_FUNC, CMD_CGRAM, CMD_DDRAM);
  - CHAR_SPACE=8'h20;
  - FSM state encoding (IDLE, CLEARING, BUSY).
- One sub-module: lcd_bus_sync, which holds the 3-stage input registers and falling-edge strobe generation.

Test Plan:
- Reset released → busy=1 for CLEAR_CYCLES+1 cycles; then scanning rd_addr 0..31 returns 0x20 everywhere; cursor_addr=0.
- Writes 0x38, 0x0C, 0x01, 0x06, spaced 50000 cycles → display_on=1, cursor_on=0, cursor_addr=0, increment=1, no protocol_err.
- Data "WASH" spaced 50000 cycles → DDRAM[0..3]=0x57, 0x41, 0x53, 0x48; cursor_addr=4.
- Wrap and entry mode:
  - 0x9F, then 'X', 'Y' → DDRAM[31]=0x58, DDRAM[0]=0x59, cursor=1.
  - Then 0x04, 0x80, 'Z' → DDRAM[0]=0x5A, cursor=31.
- Busy and status read:
  - Write 'A' at cursor 5, then an immediate status read → data_oe=1, data_out=0x86.
  - A second write within BUSY_CYCLES → protocol_err pulses, DDRAM[6] unchanged.
  - Status read after busy ends → data_out=0x06.
- Reset mid-CLEARING (after 0x01, 10 cycles in) → outputs at reset values; after release a full clear completes with busy=1 for CLEAR_CYCLES+1 cycles.
